// File: rtl/iq_comp_pkg.sv
// Shared encodings and arithmetic helpers for the IQ imbalance compensator.
package iq_comp_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'b00,
    MODE_INT_W   = 2'b01,
    MODE_EXT_W   = 2'b10,
    MODE_BYPASS2 = 2'b11
  } op_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ADAPT   = 2'b01,
    ST_SETTLED = 2'b10
  } state_t;

  // Wide enough that no intermediate product or sum can wrap for sane DW/WW.
  localparam int AW = 48;
  typedef logic signed [AW-1:0] acc_t;

  function automatic acc_t sat(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic acc_t abs_acc(input acc_t x);
    return (x < 0) ? -x : x;
  endfunction

endpackage

// File: rtl/iq_comp_adapt_settle.sv
// Settle detector: counts consecutive quiet coefficient updates.
module iq_settle_det
  import iq_comp_pkg::*;
#(
  parameter int SETTLE_CNT = 256,
  parameter int SETTLE_THR = 2
) (
  input  logic clk,
  input  logic RESETn,
  input  logic upd,
  input  logic clear,
  input  acc_t d_wr,
  input  acc_t d_wj,
  output logic hit
);

  localparam int CW = $clog2(SETTLE_CNT + 1);

  logic [CW-1:0] cnt_reg;
  logic          quiet;

  assign quiet = (abs_acc(d_wr) <= acc_t'(SETTLE_THR)) &&
                 (abs_acc(d_wj) <= acc_t'(SETTLE_THR));

  // The update that lands on SETTLE_CNT-1 is the one that completes the run.
  assign hit = upd && quiet && (cnt_reg == CW'(SETTLE_CNT - 1));

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (upd) begin
      cnt_reg <= quiet ? cnt_reg + 1'b1 : '0;
    end
  end

endmodule

// File: rtl/iq_comp_adapt.sv
// Blind IQ imbalance compensator with LMS-style coefficient adaptation.
module iq_comp_adapt
  import iq_comp_pkg::*;
#(
  parameter int DW         = 4,
  parameter int WW         = 13,
  parameter int SETTLE_CNT = 256,
  parameter int SETTLE_THR = 2
) (
  input  logic                 clk,
  input  logic                 RESETn,
  input  logic                 in_valid,
  input  logic [DW-1:0]        Ix,
  input  logic [DW-1:0]        Qx,
  input  logic [1:0]           op_mode,
  input  logic                 freeze,
  input  logic                 restart,
  input  logic [3:0]           comp_shift,
  input  logic [3:0]           mu_shift,
  input  logic signed [WW-1:0] Wr_in,
  input  logic signed [WW-1:0] Wj_in,
  output logic                 out_valid,
  output logic signed [DW-1:0] Iy,
  output logic signed [DW-1:0] Qy,
  output logic signed [WW-1:0] Wr,
  output logic signed [WW-1:0] Wj,
  output logic                 settled,
  output logic [1:0]           state
);

  state_t               state_reg, state_next;
  logic                 out_valid_reg;
  logic signed [DW-1:0] iy_reg, qy_reg, iy_next, qy_next;
  logic signed [WW-1:0] wr_reg, wj_reg, wr_next, wj_next;
  logic signed [DW-1:0] ix_sn, qx_sn;
  acc_t                 ix_a, qx_a, wr_sel, wj_sel, s_i, s_q;
  acc_t                 iy_a, qy_a, d_wr, d_wj;
  logic                 upd, enter_adapt, settle_hit;

  // Offset-binary to two's complement is just an MSB flip.
  assign ix_sn = {~Ix[DW-1], Ix[DW-2:0]};
  assign qx_sn = {~Qx[DW-1], Qx[DW-2:0]};
  assign ix_a  = acc_t'(ix_sn);
  assign qx_a  = acc_t'(qx_sn);

  always_comb begin
    wr_sel  = acc_t'(wr_reg);
    wj_sel  = acc_t'(wj_reg);
    if (op_mode == MODE_EXT_W) begin
      wr_sel = acc_t'(Wr_in);
      wj_sel = acc_t'(Wj_in);
    end
    s_i     = (wr_sel * ix_a + wj_sel * qx_a) >>> comp_shift;
    s_q     = (wj_sel * ix_a - wr_sel * qx_a) >>> comp_shift;
    iy_next = ix_sn;
    qy_next = qx_sn;
    if (op_mode == MODE_INT_W || op_mode == MODE_EXT_W) begin
      iy_next = DW'(sat(ix_a + s_i, DW));
      qy_next = DW'(sat(qx_a + s_q, DW));
    end
  end

  // Gradient terms drive the image-rejection error towards zero.
  assign iy_a = acc_t'(iy_reg);
  assign qy_a = acc_t'(qy_reg);
  assign d_wr = ((iy_a + qy_a) * (iy_a - qy_a)) >>> mu_shift;
  assign d_wj = (acc_t'(2) * iy_a * qy_a) >>> mu_shift;

  assign upd = out_valid_reg && (state_reg == ST_ADAPT) && !freeze &&
               (op_mode == MODE_INT_W);

  always_comb begin
    wr_next = '0;
    wj_next = '0;
    case (op_mode)
      MODE_INT_W: begin
        wr_next = wr_reg;
        wj_next = wj_reg;
        if (upd) begin
          wr_next = WW'(sat(acc_t'(wr_reg) - d_wr, WW));
          wj_next = WW'(sat(acc_t'(wj_reg) - d_wj, WW));
        end
      end
      MODE_EXT_W: begin
        wr_next = Wr_in;
        wj_next = Wj_in;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    enter_adapt = 1'b0;
    if (op_mode != MODE_INT_W) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next  = ST_ADAPT;
          enter_adapt = 1'b1;
        end
        ST_ADAPT:   if (settle_hit) state_next = ST_SETTLED;
        ST_SETTLED: if (restart) begin
          state_next  = ST_ADAPT;
          enter_adapt = 1'b1;
        end
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      iy_reg        <= '0;
      qy_reg        <= '0;
      wr_reg        <= '0;
      wj_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= in_valid;
      wr_reg        <= wr_next;
      wj_reg        <= wj_next;
      if (in_valid) begin
        iy_reg <= iy_next;
        qy_reg <= qy_next;
      end
    end
  end

  iq_settle_det #(
    .SETTLE_CNT(SETTLE_CNT),
    .SETTLE_THR(SETTLE_THR)
  ) u_settle (
    .clk   (clk),
    .RESETn(RESETn),
    .upd   (upd),
    .clear (enter_adapt),
    .d_wr  (d_wr),
    .d_wj  (d_wj),
    .hit   (settle_hit)
  );

  assign out_valid = out_valid_reg;
  assign Iy        = iy_reg;
  assign Qy        = qy_reg;
  assign Wr        = wr_reg;
  assign Wj        = wj_reg;
  assign settled   = (state_reg == ST_SETTLED);
  assign state     = state_reg;

endmodule
